// File: rtl/blackice_pll_reset_ctrl_if.sv
// rtl/blackice_pll_reset_ctrl_if.sv - lock and status signals between PLL environment and reset controller
interface blackice_pll_reset_ctrl_if #(
  parameter int LOSS_COUNT_WIDTH = 8
);
  logic                        pll_locked;
  logic                        clear_status;
  logic                        system_reset;
  logic                        ready;
  logic                        lock_lost;
  logic [LOSS_COUNT_WIDTH-1:0] loss_count;

  // Environment side: supplies the raw lock and clear pulse, observes reset/status
  modport master (
    output pll_locked,
    output clear_status,
    input  system_reset,
    input  ready,
    input  lock_lost,
    input  loss_count
  );

  // Controller side
  modport slave (
    input  pll_locked,
    input  clear_status,
    output system_reset,
    output ready,
    output lock_lost,
    output loss_count
  );
endinterface

// File: rtl/blackice_pll_reset_ctrl.sv
// rtl/blackice_pll_reset_ctrl.sv - PLL lock qualifier that sequences the SoC reset and records lock losses
module blackice_pll_reset_ctrl #(
  parameter int STABLE_CYCLES     = 1024,
  parameter int RESET_HOLD_CYCLES = 64,
  parameter int LOSS_COUNT_WIDTH  = 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  blackice_pll_reset_ctrl_if.slave  bus
);

  // One counter serves both timed states, so it is sized for the longer one.
  // It only ever reaches (cycles - 1), hence clog2 of the maximum is enough.
  localparam int MAX_CYCLES = (STABLE_CYCLES > RESET_HOLD_CYCLES) ? STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                      state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [1:0]                  sync_q;
  logic                        system_reset_q;
  logic                        ready_q;
  logic                        lock_lost_q;
  logic [LOSS_COUNT_WIDTH-1:0] loss_count_q;
  logic                        locked_s;

  assign locked_s = sync_q[1];

  // Two-flop synchroniser bringing the asynchronous PLL lock into the clock domain
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked};
    end
  end

  // Lock qualification FSM with registered reset/ready outputs and loss bookkeeping
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      system_reset_q <= 1'b1;
      ready_q        <= 1'b0;
      lock_lost_q    <= 1'b0;
      loss_count_q   <= '0;
    end else begin
      // Clear is applied first so that a loss on the same edge overrides it below.
      if (bus.clear_status) begin
        lock_lost_q  <= 1'b0;
        loss_count_q <= '0;
      end

      case (state_q)
        WAIT_LOCK: begin
          cnt_q <= '0;
          if (locked_s) begin
            state_q <= STABILIZE;
          end
        end

        STABILIZE: begin
          // A dip before RUN just restarts qualification; it is not a loss.
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        HOLD: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            system_reset_q <= 1'b0;
            ready_q        <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        RUN: begin
          cnt_q <= '0;
          if (!locked_s) begin
            state_q        <= WAIT_LOCK;
            system_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            lock_lost_q    <= 1'b1;
            if (bus.clear_status) begin
              loss_count_q <= LOSS_COUNT_WIDTH'(1);
            end else if (!(&loss_count_q)) begin
              loss_count_q <= loss_count_q + LOSS_COUNT_WIDTH'(1);
            end
          end
        end

        default: begin
          state_q        <= WAIT_LOCK;
          cnt_q          <= '0;
          system_reset_q <= 1'b1;
          ready_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.system_reset = system_reset_q;
  assign bus.ready        = ready_q;
  assign bus.lock_lost    = lock_lost_q;
  assign bus.loss_count   = loss_count_q;

endmodule

// File: doc/blackice_pll_reset_ctrl.md
# blackice_pll_reset_ctrl

Lock-consumer for the BlackIce PLL. It runs in the PLL output clock domain, synchronises the PLL's asynchronous lock indication, and requires lock to stay continuously stable before releasing the system reset. On any loss of lock it reasserts the system reset and records the event. It sits between the PLL instance and the SoC reset tree.

## Interface
- `STABLE_CYCLES`, default 1024: consecutive synchronised-lock cycles required before reset hold begins; must be ≥1.
- `RESET_HOLD_CYCLES`, default 64: cycles `system_reset` stays asserted after lock is deemed stable; must be ≥1.
- `LOSS_COUNT_WIDTH`, default 8: width of the saturating lock-loss counter; must be ≥1.

Ports (name, direction, width, meaning):
- `clock` in 1: PLL output clock. The block's only clock.
- `resetn` in 1: synchronous, active-low block reset.
- `pll_locked` in 1: raw PLL lock. Asynchronous to `clock`.
- `clear_status` in 1: single-cycle pulse that clears `lock_lost` and `loss_count`.
- `system_reset` out 1: active-high reset to the SoC.
- `ready` out 1: high only in RUN.
- `lock_lost` out 1: sticky flag, set on a loss of lock from RUN.
- `loss_count` out `LOSS_COUNT_WIDTH`: saturating count of losses of lock from RUN.

## Operation
- **Synchroniser:** two-flop synchroniser on `pll_locked` produces `locked_s`. The FSM uses only `locked_s`.
- **State machine:** one-hot or binary, implementer's choice. States are WAIT_LOCK, STABILIZE, HOLD, RUN. There is one shared down/up counter, wide enough for max(`STABLE_CYCLES`, `RESET_HOLD_CYCLES`).
- **WAIT_LOCK:** counter held at 0. If `locked_s`=1, go to STABILIZE.
- **STABILIZE:**
  - Counter increments every cycle.
  - If `locked_s`=0, go to WAIT_LOCK. This is not counted as a loss.
  - After exactly `STABLE_CYCLES` cycles in the state, go to HOLD with the counter cleared.
- **HOLD:**
  - If `locked_s`=0, go to WAIT_LOCK. This is not counted as a loss.
  - After exactly `RESET_HOLD_CYCLES` cycles in the state, go to RUN.
- **RUN:** if `locked_s`=0, go to WAIT_LOCK, set `lock_lost`, and increment `loss_count`. The count saturates at all-ones and does not wrap.
- **Output registers:**
  - `system_reset`=1 and `ready`=0 in every state except RUN.
  - Both are registered outputs that change on the same edge as the state register.
- **Status clear:**
  - `clear_status`=1 clears `lock_lost` and `loss_count` on the next edge.
  - If a loss event occurs on the same edge as a clear, the loss wins: `lock_lost`=1 and `loss_count`=1.
  - `clear_status` has no effect on the FSM.
- **Reset values:** `resetn`=0 at an edge forces synchroniser flops=0, state=WAIT_LOCK, counter=0, `system_reset`=1, `ready`=0, `lock_lost`=0, `loss_count`=0.
  - Applies equally mid-operation.
  - Reset wins over all simultaneous events.

## Timing
- **Lock latency:** `pll_locked` is first sampled high at edge k.
  - `locked_s`=1 after edge k+1.
  - The FSM is in STABILIZE after edge k+2.
  - The FSM is in HOLD after edge k+2+`STABLE_CYCLES`.
  - The FSM is in RUN, with `system_reset`=0 and `ready`=1, after edge k+2+`STABLE_CYCLES`+`RESET_HOLD_CYCLES`.
  - The lock input must remain high throughout.
- **Loss latency:** `pll_locked` is first sampled low at edge m while in RUN.
  - `system_reset`=1, `ready`=0, `lock_lost`=1 and updated `loss_count` all take effect after edge m+2.
- **Glitch filtering:**
  - Pulses on `pll_locked` narrower than one clock period may be missed entirely.
  - Any dip seen on `locked_s` before RUN restarts the full latency.
- **After block reset:** `pll_locked` held high while `resetn` is released at edge r gives RUN after edge r+3+`STABLE_CYCLES`+`RESET_HOLD_CYCLES`. The synchroniser refills first.

## Test plan
1. **Clean lock.** `STABLE_CYCLES`=4, `RESET_HOLD_CYCLES`=2, `pll_locked` first sampled high at edge 10 → `system_reset` falls and `ready` rises after edge 18 and stay there; `loss_count`=0.
2. **Glitch in STABILIZE.** Same parameters, `pll_locked` high 3 cycles then low 1 cycle then high → no release during the glitch; release occurs 8 edges after the re-rise is sampled; `lock_lost`=0, `loss_count`=0.
3. **Loss in RUN.** From RUN, drop `pll_locked` at edge m → `system_reset`=1 after edge m+2, `lock_lost`=1, `loss_count`=1; raise again → RUN reached after full latency; `lock_lost` still 1.
4. **Saturation.** `LOSS_COUNT_WIDTH`=2, five lock/loss cycles each reaching RUN → `loss_count` sequence 1,2,3,3,3.
5. **Clear handling.** `clear_status` pulse alone → `lock_lost`=0, `loss_count`=0 next edge. `clear_status` on the same edge as a loss with `loss_count`=2 beforehand → `loss_count`=1, `lock_lost`=1.
6. **Block reset mid-RUN.** `resetn`=0 for one edge while in RUN with `loss_count`=3 → all outputs at reset values after that edge; release with `pll_locked` high → RUN after edge r+9 (r = release edge).
